smg_capture: RTL
================

SMG_CAPTURE -- requirements
Module: smg_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, meaning the number of consecutive identical samples needed to accept a digit (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port smg_sig  input  6  digit-select bus, active-low, as driven to the display.
REQ-005 SHALL have port smg_data  input  8  common-anode segment code, A..G = bit0..bit6, DP = bit7.
REQ-006 SHALL have port data  output  8  last reconstructed byte: high nibble from digit 2, low nibble from digit 1.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse when data is updated.
REQ-008 SHALL have port code_err  output  1  one-cycle pulse when an accepted sample holds a non-hex segment code.

Function
REQ-009 SHALL register smg_sig and smg_data once on input; all decisions SHALL use the registered copies.
REQ-010 SHALL treat smg_sig 6'b111110 as digit 1 (low nibble) and 6'b111101 as digit 2 (high nibble); every other value is idle, SHALL clear the stability counter, and SHALL NOT disturb held nibbles.
REQ-011 SHALL keep a stability counter that increments while the registered {sig,data} equals the previous cycle's value, reloads to 1 on any change, and saturates at STABLE_CNT.
REQ-012 SHALL accept a sample exactly once, in the cycle the counter reaches STABLE_CNT.
REQ-013 SHALL decode an accepted code with the common-anode table: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E map to 0..F.
REQ-014 SHALL run the FSM states SEEK, HAVE_LO, HAVE_HI and EMIT.
REQ-015 SEEK SHALL move to HAVE_LO on an accepted digit 1 and to HAVE_HI on an accepted digit 2, storing the nibble.
REQ-016 HAVE_LO SHALL move to EMIT on an accepted digit 2; HAVE_HI SHALL move to EMIT on an accepted digit 1.
REQ-017 In HAVE_LO or HAVE_HI, a repeated acceptance of the same digit SHALL overwrite the stored nibble and keep the state.
REQ-018 EMIT SHALL load data = {hi,lo}, pulse data_valid for one cycle, and return to SEEK; data SHALL hold between updates.
REQ-019 Latency SHALL be: the cycle the second digit is accepted, plus 1 cycle to EMIT, plus 1 cycle for the data/data_valid register.
REQ-020 An invalid code on acceptance SHALL pulse code_err the next cycle, discard both stored nibbles, and force SEEK; data SHALL be unchanged.
REQ-021 Idle select values SHALL NOT abort a partial capture; interleaved blanking between digits is legal.

Reset
REQ-022 While rst=1, the block SHALL set data=8'h00, data_valid=0, code_err=0, FSM=SEEK, stability counter=0, stored nibbles=0, and input registers = idle (6'h3F, 8'hFF).
REQ-023 Reset asserted mid-capture SHALL discard any partial byte; the first data_valid after reset SHALL require two fresh acceptances.

Configuration
REQ-024 With macro SMG_CAPTURE_DP_CHECK_EN defined, an accepted code with DP lit (bit7=0) SHALL be treated as invalid per REQ-020.
REQ-025 Without SMG_CAPTURE_DP_CHECK_EN, bit7 SHALL be ignored for decoding (decode on {1'b1, code[6:0]}).

Structure
REQ-026 Shared package smg_pkg SHALL hold the sixteen segment constants, the two digit-select constants, the idle values and the FSM state type.
REQ-027 Decoding SHALL sit in combinational sub-module smg_seg2hex (in: 8-bit code; out: 4-bit nibble, valid flag), reused by later display blocks.

Verification
REQ-028 Alternate digit 1 = 8'h99 and digit 2 = 8'hA4, 8 cycles each, STABLE_CNT=4 -> data=8'h24 with one data_valid pulse per digit pair.
REQ-029 Hold digit 1 = 8'hC0 for only 3 cycles, then blank -> no acceptance, no data_valid, no code_err.
REQ-030 Drive digit 2 = 8'h8E, then digit 1 = 8'hFF, each stable -> code_err pulses once, data keeps its prior value, and the next valid pair 8'h80/8'hF9 emits 8'h18.
REQ-031 Drive digit 1 = 8'h40 (0 with DP lit) -> code_err when SMG_CAPTURE_DP_CHECK_EN is defined; otherwise the low nibble is 0 and there is no error.
REQ-032 Accept digit 1 = 8'hB0, assert rst for 1 cycle, then accept digit 2 = 8'h92 only -> no data_valid, and data = 8'h00.
REQ-033 Feed digit 1 = 8'hF8, then digit 1 = 8'h86, then digit 2 = 8'h88, with 6'h3F blanking between each -> one data_valid with data = 8'hAE.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment capture path and later display blocks.
// Holds the common-anode segment codes for 0..F, the two digit-select codes,
// the idle bus values and the capture FSM state type.
package smg_pkg;

  localparam int unsigned SIG_W  = 6;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned NIB_W  = 4;

  // Common-anode codes, A..G = bit0..bit6, DP = bit7 (all unlit DP)
  localparam logic [SEG_W-1:0] SEG_0 = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1 = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2 = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3 = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4 = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5 = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6 = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7 = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8 = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9 = 8'h90;
  localparam logic [SEG_W-1:0] SEG_A = 8'h88;
  localparam logic [SEG_W-1:0] SEG_B = 8'h83;
  localparam logic [SEG_W-1:0] SEG_C = 8'hC6;
  localparam logic [SEG_W-1:0] SEG_D = 8'hA1;
  localparam logic [SEG_W-1:0] SEG_E = 8'h86;
  localparam logic [SEG_W-1:0] SEG_F = 8'h8E;

  // Active-low digit selects
  localparam logic [SIG_W-1:0] SIG_DIG1 = 6'b111110;  // low nibble
  localparam logic [SIG_W-1:0] SIG_DIG2 = 6'b111101;  // high nibble

  // Bus values while nothing is displayed
  localparam logic [SIG_W-1:0] SIG_IDLE  = 6'h3F;
  localparam logic [SEG_W-1:0] DATA_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    HAVE_LO = 2'd1,
    HAVE_HI = 2'd2,
    EMIT    = 2'd3
  } state_t;

endpackage

// File: rtl/smg_seg2hex.sv
// Combinational common-anode segment code to hex nibble decoder.
// Ports:
//   code_i   - 8-bit segment code (A..G = bit0..bit6, DP = bit7)
//   nibble_o - decoded value 0..F (0 when the code is not in the table)
//   valid_o  - 1 when code_i exactly matches one of the sixteen codes
module smg_seg2hex
  import smg_pkg::*;
(
  input  logic [SEG_W-1:0] code_i,
  output logic [NIB_W-1:0] nibble_o,
  output logic             valid_o
);

  always_comb begin
    nibble_o = '0;
    valid_o  = 1'b1;
    unique case (code_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/smg_capture.sv
// Reconstructs a byte from a two-digit multiplexed seven-segment display bus.
// Each digit must be seen unchanged for STABLE_CNT registered samples before
// it is accepted; digit 1 supplies the low nibble, digit 2 the high nibble.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   smg_sig    - active-low digit select as driven to the display
//   smg_data   - common-anode segment code
//   data       - last reconstructed byte {digit2, digit1}
//   data_valid - one-cycle pulse when data updates
//   code_err   - one-cycle pulse when an accepted sample is not a hex code
// Build option: define SMG_CAPTURE_DP_CHECK_EN to reject accepted codes with
// the decimal point lit; otherwise the DP bit is ignored.
module smg_capture
  import smg_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIG_W-1:0] smg_sig,
  input  logic [SEG_W-1:0] smg_data,
  output logic [SEG_W-1:0] data,
  output logic             data_valid,
  output logic             code_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SMP_W = SIG_W + SEG_W;
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);

  logic [SIG_W-1:0] sig_q;
  logic [SEG_W-1:0] seg_q;
  logic [SMP_W-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q;
  logic [NIB_W-1:0] lo_q, hi_q;
  logic [SEG_W-1:0] data_q;
  logic             data_valid_q, code_err_q;

  logic             is_dig1_c, is_dig2_c, is_digit_c;
  logic             accept_c;
  logic [SEG_W-1:0] code_c;
  logic             dp_lit_c;
  logic [NIB_W-1:0] dec_nib_c;
  logic             dec_ok_c;
  logic             code_bad_c;

`ifdef SMG_CAPTURE_DP_CHECK_EN
  assign code_c   = seg_q;
  assign dp_lit_c = ~seg_q[7];
`else
  assign code_c   = {1'b1, seg_q[6:0]};
  assign dp_lit_c = 1'b0;
`endif

  smg_seg2hex u_dec (
    .code_i   (code_c),
    .nibble_o (dec_nib_c),
    .valid_o  (dec_ok_c)
  );

  assign code_bad_c = ~dec_ok_c | dp_lit_c;

  // Stability counter and single-shot acceptance
  always_comb begin
    is_dig1_c  = (sig_q == SIG_DIG1);
    is_dig2_c  = (sig_q == SIG_DIG2);
    is_digit_c = is_dig1_c | is_dig2_c;
    cnt_d      = '0;
    if (!is_digit_c) begin
      cnt_d = '0;
    end else if ({sig_q, seg_q} == prev_q) begin
      cnt_d = (cnt_q >= STABLE_V) ? STABLE_V : CNT_W'(cnt_q + 1'b1);
    end else begin
      cnt_d = CNT_W'(1);
    end
    // Fires only on the transition into saturation, so a held digit counts once
    accept_c = is_digit_c && (cnt_d == STABLE_V) && (cnt_q != STABLE_V);
  end

  // Input registers, capture FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q        <= SIG_IDLE;
      seg_q        <= DATA_IDLE;
      prev_q       <= {SIG_IDLE, DATA_IDLE};
      cnt_q        <= '0;
      state_q      <= SEEK;
      lo_q         <= '0;
      hi_q         <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      sig_q        <= smg_sig;
      seg_q        <= smg_data;
      prev_q       <= {sig_q, seg_q};
      cnt_q        <= cnt_d;
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;

      if (state_q == EMIT) begin
        data_q       <= {hi_q, lo_q};
        data_valid_q <= 1'b1;
        state_q      <= SEEK;
      end else if (accept_c) begin
        if (code_bad_c) begin
          // Bad code poisons the pair in progress
          code_err_q <= 1'b1;
          lo_q       <= '0;
          hi_q       <= '0;
          state_q    <= SEEK;
        end else if (is_dig1_c) begin
          lo_q    <= dec_nib_c;
          state_q <= (state_q == HAVE_HI) ? EMIT : HAVE_LO;
        end else begin
          hi_q    <= dec_nib_c;
          state_q <= (state_q == HAVE_LO) ? EMIT : HAVE_HI;
        end
      end
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign code_err   = code_err_q;

endmodule
